pix_scaler_nx: RTL and testbench

- Parametrised integer pixel-replication scaler, successor to the fixed 2x line doubler in the video output path.
- Buffers one input line at the core pixel rate.
- Replays each buffered line 1x–4x horizontally and vertically at the output pixel rate, with optional scanline darkening on the last replicated row.
- Sits between the core video generator and the video mixer/output sync stage.

---
 rtl/video_pkg.sv | 15 +
 rtl/pix_scaler_lbuf.sv | 29 ++
 rtl/pix_scaler_nx.sv | 175 +++++++++++++++++
 tb/tb_pix_scaler_nx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: scanline darkening modes and the per-channel width helper.
package video_pkg;

  typedef enum logic [1:0] {
    SCAN_OFF = 2'd0,
    SCAN_75  = 2'd1,
    SCAN_50  = 2'd2,
    SCAN_25  = 2'd3
  } scan_mode_e;

  function automatic int chanWidth(input int dwidth);
    return dwidth / 3;
  endfunction

endpackage

// File: rtl/pix_scaler_lbuf.sv
// Ping-pong pair of line buffers. There is one write port and one synchronous read port,
// and each port picks its half with a buffer-select bit. The contents are never reset.
module pix_scaler_lbuf
  import video_pkg::*;
#(
  parameter int LENGTH = 1024,
  parameter int DWIDTH = 24
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic                       wsel_i,
  input  logic [$clog2(LENGTH)-1:0]  waddr_i,
  input  logic [DWIDTH-1:0]          wdata_i,
  input  logic                       re_i,
  input  logic                       rsel_i,
  input  logic [$clog2(LENGTH)-1:0]  raddr_i,
  output logic [DWIDTH-1:0]          rdata_o
);
  localparam int AW = $clog2(LENGTH);

  logic [DWIDTH-1:0] mem [2**(AW+1)];

  // The read data holds between read enables, so the output stage sees a stable q.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[{wsel_i, waddr_i}] <= wdata_i;
    if (re_i) rdata_o <= mem[{rsel_i, raddr_i}];
  end

endmodule

// File: rtl/pix_scaler_nx.sv
// Integer pixel-replication scaler. It buffers one input line at the core pixel rate and
// replays that line 1x-4x in both directions at the output rate, with optional scanlines.
module pix_scaler_nx
  import video_pkg::*;
#(
  parameter int LENGTH      = 1024,
  parameter int DWIDTH      = 24,
  parameter bit SCANLINE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_in,
  input  logic [DWIDTH-1:0] pix_in,
  input  logic              reset_line,
  input  logic              reset_frame,
  input  logic [1:0]        scale,
  input  logic [1:0]        scanline_mode,
  input  logic              ce_out,
  input  logic              hblank,
  output logic [DWIDTH-1:0] pix_out,
  output logic              overflow
);
  localparam int          AW     = $clog2(LENGTH);
  localparam int          CW     = chanWidth(DWIDTH);
  localparam logic [AW:0] LenMax = (AW+1)'(LENGTH);
  localparam logic [AW:0] One    = (AW+1)'(1);

  logic [AW:0]       wrX_q, wrX_d, wrLen_q, wrLen_d, rdX_q, rdX_d;
  logic              wrBuf_q, wrBuf_d, rdBuf_q, rdBuf_d;
  logic [1:0]        factorM1_q, factorM1_d, hx_q, hx_d, repY_q, repY_d;
  scan_mode_e        mode_q, mode_d;
  logic              overflow_q, overflow_d, lineQ_q, lineQ_d, frameQ_q, frameQ_d;
  logic              hblankQ_q, hblankQ_d, valid_q, valid_d;
  logic [DWIDTH-1:0] pixOut_q, pixOut_d, rdData;
  logic              we, lineCommit, frameCommit, darkOn;

  function automatic logic [DWIDTH-1:0] darken(input logic [DWIDTH-1:0] p,
                                               input scan_mode_e m);
    logic [CW-1:0] c;
    darken = p;
    for (int i = 0; i < 3; i++) begin
      c = p[i*CW +: CW];
      case (m)
        SCAN_75: darken[i*CW +: CW] = c - (c >> 2);
        SCAN_50: darken[i*CW +: CW] = c >> 1;
        SCAN_25: darken[i*CW +: CW] = c >> 2;
        default: darken[i*CW +: CW] = c;
      endcase
    end
  endfunction

  // A line edge is detected only between two consecutive ce_in samples.
  assign lineCommit  = ce_in & reset_line & ~lineQ_q;
  assign frameCommit = lineCommit & ~reset_frame & frameQ_q;
  assign darkOn      = SCANLINE_EN && (mode_q != SCAN_OFF) && (factorM1_q != 2'd0) &&
                       (repY_q == factorM1_q);

  always_comb begin
    wrX_d      = wrX_q;
    wrLen_d    = wrLen_q;
    wrBuf_d    = wrBuf_q;
    rdBuf_d    = rdBuf_q;
    factorM1_d = factorM1_q;
    mode_d     = mode_q;
    overflow_d = overflow_q;
    lineQ_d    = lineQ_q;
    frameQ_d   = frameQ_q;
    we         = 1'b0;
    if (ce_in) begin
      lineQ_d  = reset_line;
      frameQ_d = reset_frame;
      if (lineCommit) begin
        wrLen_d    = wrX_q;
        wrX_d      = '0;
        rdBuf_d    = wrBuf_q;
        wrBuf_d    = ~wrBuf_q;
        factorM1_d = scale;
        mode_d     = scan_mode_e'(scanline_mode);
        if (frameCommit) begin
          wrBuf_d    = 1'b0;
          rdBuf_d    = 1'b1;
          overflow_d = 1'b0;
        end
      end else if (!reset_line) begin
        if (wrX_q == LenMax) begin
          overflow_d = 1'b1;
        end else begin
          we    = 1'b1;
          wrX_d = wrX_q + One;
        end
      end
    end
  end

  // The output register shows the pixel that was addressed at the previous ce_out.
  always_comb begin
    rdX_d     = rdX_q;
    hx_d      = hx_q;
    repY_d    = repY_q;
    hblankQ_d = hblankQ_q;
    valid_d   = valid_q;
    pixOut_d  = pixOut_q;
    if (ce_out) begin
      hblankQ_d = hblank;
      valid_d   = ~hblank & (rdX_q < wrLen_q);
      pixOut_d  = !valid_q ? '0 : (darkOn ? darken(rdData, mode_q) : rdData);
      if (hblank) begin
        rdX_d = '0;
        hx_d  = 2'd0;
        if (!hblankQ_q && (repY_q != factorM1_q)) repY_d = repY_q + 2'd1;
      end else if (hx_q == factorM1_q) begin
        hx_d = 2'd0;
        if (rdX_q != LenMax) rdX_d = rdX_q + One;
      end else begin
        hx_d = hx_q + 2'd1;
      end
    end
    if (lineCommit) repY_d = 2'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrX_q      <= '0;
      wrLen_q    <= '0;
      rdX_q      <= '0;
      wrBuf_q    <= 1'b0;
      rdBuf_q    <= 1'b0;
      factorM1_q <= 2'd0;
      hx_q       <= 2'd0;
      repY_q     <= 2'd0;
      mode_q     <= SCAN_OFF;
      overflow_q <= 1'b0;
      lineQ_q    <= 1'b0;
      frameQ_q   <= 1'b0;
      hblankQ_q  <= 1'b0;
      valid_q    <= 1'b0;
      pixOut_q   <= '0;
    end else begin
      wrX_q      <= wrX_d;
      wrLen_q    <= wrLen_d;
      rdX_q      <= rdX_d;
      wrBuf_q    <= wrBuf_d;
      rdBuf_q    <= rdBuf_d;
      factorM1_q <= factorM1_d;
      hx_q       <= hx_d;
      repY_q     <= repY_d;
      mode_q     <= mode_d;
      overflow_q <= overflow_d;
      lineQ_q    <= lineQ_d;
      frameQ_q   <= frameQ_d;
      hblankQ_q  <= hblankQ_d;
      valid_q    <= valid_d;
      pixOut_q   <= pixOut_d;
    end
  end

  pix_scaler_lbuf #(
    .LENGTH(LENGTH),
    .DWIDTH(DWIDTH)
  ) u_lbuf (
    .clk_i  (clk),
    .we_i   (we),
    .wsel_i (wrBuf_q),
    .waddr_i(wrX_q[AW-1:0]),
    .wdata_i(pix_in),
    .re_i   (ce_out),
    .rsel_i (rdBuf_q),
    .raddr_i(rdX_q[AW-1:0]),
    .rdata_o(rdData)
  );

  assign pix_out  = pixOut_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pix_scaler_nx.sv
// Directed bench for pix_scaler_nx with a 16-pixel line buffer. The expected pixels come from
// the line contents written by the bench, the replication factor and hand-computed darkening.
module tb_pix_scaler_nx;
  localparam int LENGTH = 16;
  localparam int DWIDTH = 24;

  logic              clk = 1'b0;
  logic              reset_n, ce_in, reset_line, reset_frame, ce_out, hblank, overflow;
  logic [DWIDTH-1:0] pix_in, pix_out;
  logic [1:0]        scale, scanline_mode;

  int checks   = 0;
  int failures = 0;

  // Index 0 is the undarkened pixel; 1..3 are the 75%, 50% and 25% versions of 0xFF8040.
  logic [DWIDTH-1:0] darkExp [4] = '{24'hFF8040, 24'hC06030, 24'h7F4020, 24'h3F2010};

  pix_scaler_nx #(
    .LENGTH     (LENGTH),
    .DWIDTH     (DWIDTH),
    .SCANLINE_EN(1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce_in        (ce_in),
    .pix_in       (pix_in),
    .reset_line   (reset_line),
    .reset_frame  (reset_frame),
    .scale        (scale),
    .scanline_mode(scanline_mode),
    .ce_out       (ce_out),
    .hblank       (hblank),
    .pix_out      (pix_out),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DWIDTH-1:0] observed,
                             input logic [DWIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Writes one input line of n pixels: base, base+step, ...
  task automatic applyStimulus(input int n, input logic [DWIDTH-1:0] base,
                               input logic [DWIDTH-1:0] step);
    for (int i = 0; i < n; i++) begin
      pix_in     = base + DWIDTH'(i) * step;
      reset_line = 1'b0;
      ce_in      = 1'b1;
      tick();
    end
    ce_in = 1'b0;
  endtask

  task automatic commitLine(input logic [1:0] sc, input logic [1:0] md);
    scale         = sc;
    scanline_mode = md;
    reset_line    = 1'b1;
    reset_frame   = 1'b0;
    ce_in         = 1'b1;
    tick();
    ce_in = 1'b0;
  endtask

  function automatic logic [DWIDTH-1:0] expPix(input int k, input int f, input int len,
                                               input logic [DWIDTH-1:0] base,
                                               input logic [DWIDTH-1:0] step);
    int idx;
    idx = k / f;
    if (idx >= len) return '0;
    return base + DWIDTH'(idx) * step;
  endfunction

  // Plays one output row of n active ce_out, followed by two hblank ce_out.
  task automatic playRow(input string tag, input int n, input int f, input int len,
                         input logic [DWIDTH-1:0] base, input logic [DWIDTH-1:0] step,
                         input bit slow);
    logic [DWIDTH-1:0] exp;
    for (int k = 0; k < n; k++) begin
      hblank = 1'b0;
      ce_out = 1'b1;
      tick();
      exp = (k == 0) ? {DWIDTH{1'b0}} : expPix(k - 1, f, len, base, step);
      checkOutput($sformatf("%s[%0d]", tag, k), pix_out, exp);
      if (slow) begin
        ce_out = 1'b0;
        tick();
        checkOutput($sformatf("%s[%0d]hold", tag, k), pix_out, exp);
        ce_out = 1'b1;
      end
    end
    hblank = 1'b1;
    tick();
    checkOutput($sformatf("%s[tail]", tag), pix_out, expPix(n - 1, f, len, base, step));
    tick();
    checkOutput($sformatf("%s[blank]", tag), pix_out, '0);
  endtask

  initial begin
    reset_n = 1'b0; ce_in = 1'b0; pix_in = '0; reset_line = 1'b1; reset_frame = 1'b0;
    scale = 2'd0; scanline_mode = 2'd0; ce_out = 1'b1; hblank = 1'b1;
    repeat (3) tick();
    checkOutput("reset_pix", pix_out, '0);
    checkOutput("reset_ovf", DWIDTH'(overflow), '0);
    reset_n = 1'b1;
    repeat (2) tick();

    $display("[TB] zero-length line");
    commitLine(2'd1, 2'd0);
    playRow("zero_len", 4, 2, 0, 24'h1, 24'h1, 1'b0);

    $display("[TB] 1x, reset_line held high for several ce_in");
    applyStimulus(8, 24'h1, 24'h1);
    commitLine(2'd0, 2'd0);
    ce_in = 1'b1;
    repeat (3) tick();
    ce_in = 1'b0;
    playRow("1x", 8, 1, 8, 24'h1, 24'h1, 1'b0);

    $display("[TB] 3x, three rows, last one at half ce_out duty");
    applyStimulus(8, 24'h1, 24'h1);
    commitLine(2'd2, 2'd0);
    playRow("3x_r0", 26, 3, 8, 24'h1, 24'h1, 1'b0);
    playRow("3x_r1", 26, 3, 8, 24'h1, 24'h1, 1'b0);
    playRow("3x_r2", 26, 3, 8, 24'h1, 24'h1, 1'b1);

    $display("[TB] 2x scanline modes");
    for (int m = 1; m < 4; m++) begin
      applyStimulus(1, 24'hFF8040, 24'h0);
      commitLine(2'd1, 2'(m));
      playRow($sformatf("scan%0d_r0", m), 3, 2, 1, darkExp[0], 24'h0, 1'b0);
      playRow($sformatf("scan%0d_r1", m), 3, 2, 1, darkExp[m], 24'h0, 1'b0);
      playRow($sformatf("scan%0d_r2", m), 3, 2, 1, darkExp[m], 24'h0, 1'b0);
    end

    $display("[TB] scale change waits for the next commit");
    applyStimulus(8, 24'h1, 24'h1);
    commitLine(2'd0, 2'd2);
    scale = 2'd3;
    applyStimulus(4, 24'h10, 24'h1);
    playRow("keep1x", 9, 1, 8, 24'h1, 24'h1, 1'b0);
    commitLine(2'd3, 2'd0);
    playRow("4x", 18, 4, 4, 24'h10, 24'h1, 1'b0);

    $display("[TB] overflow");
    applyStimulus(16, 24'h100, 24'h1);
    checkOutput("ovf_at_len", DWIDTH'(overflow), '0);
    applyStimulus(4, 24'h110, 24'h1);
    checkOutput("ovf_set", DWIDTH'(overflow), 24'h1);
    commitLine(2'd0, 2'd0);
    playRow("ovf_row", 18, 1, 16, 24'h100, 24'h1, 1'b0);
    checkOutput("ovf_sticky", DWIDTH'(overflow), 24'h1);
    reset_frame = 1'b1;
    applyStimulus(3, 24'h55, 24'h0);
    commitLine(2'd0, 2'd0);
    checkOutput("ovf_frame_clr", DWIDTH'(overflow), '0);

    $display("[TB] asynchronous reset mid-row");
    applyStimulus(20, 24'h200, 24'h1);
    commitLine(2'd0, 2'd0);
    hblank = 1'b0;
    repeat (4) tick();
    checkOutput("pre_reset_pix", pix_out, 24'h202);
    checkOutput("pre_reset_ovf", DWIDTH'(overflow), 24'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_pix", pix_out, '0);
    checkOutput("async_ovf", DWIDTH'(overflow), '0);
    hblank = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    applyStimulus(8, 24'h31, 24'h1);
    commitLine(2'd1, 2'd0);
    playRow("post_reset", 17, 2, 8, 24'h31, 24'h1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
